uart_rx_frame_checker: RTL
==========================

Name: uart_rx_frame_checker

Overview:
Registered, parametrised frame-checking stage for the UART receiver, sitting between the Rx sampling FSM and the Rx data consumer. It accepts one deserialised frame per valid/ready handshake. It checks the start, parity and stop fields, which includes a configurable data width and a second stop bit, and detects line breaks. It forwards the data with a 3-bit error flag one cycle later and keeps saturating per-error statistics counters.

Parameters:
DATA_W, 8, data bits per frame; legal range 5 to 9.
CNT_W, 8, width of each statistics counter.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  frame fields are valid.
in_ready  output  1  stage can accept a frame.
in_start  input  1  sampled start bit; 0 is legal.
in_data  input  DATA_W  sampled data, LSB first on the line.
in_parity  input  1  sampled parity bit; ignored when parity is disabled.
in_stop  input  2  [0] first stop bit, [1] second stop bit; 1 is legal.
parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
two_stop  input  1  1 checks in_stop[1] as well.
out_valid  output  1  result register holds a frame.
out_ready  input  1  consumer accepts the result.
out_data  output  DATA_W  forwarded data.
error_flag  output  3  {stop_err, start_err, parity_err}.
break_flag  output  1  the frame was a line break.
clear_cnt  input  1  synchronous clear of all counters.
frame_cnt  output  CNT_W  frames accepted.
parity_err_cnt  output  CNT_W  frames with parity_err.
start_err_cnt  output  CNT_W  frames with start_err.
stop_err_cnt  output  CNT_W  frames with stop_err.

Behaviour:
- One clock (clock). Reset is asynchronous and active-low (reset_n); it asserts immediately and releases synchronously to clock.
- Reset values: out_valid=0, out_data=0, error_flag=000, break_flag=0, and all counters=0. in_ready=1 after reset.
- Two-state FSM on the result register:
  - EMPTY: out_valid=0. An accept moves to FULL.
  - FULL: out_valid=1. out_ready with no accept moves to EMPTY. out_ready with an accept stays FULL and loads the new frame.
- in_ready = !out_valid || out_ready, combinational. Accept = in_valid && in_ready.
- Latency: a frame accepted at edge N is presented from edge N onward, meaning out_valid is high in cycle N+1. Throughput is 1 frame per cycle when out_ready is held at 1.
- While out_valid=1 and out_ready=0, the out_* outputs, error_flag and break_flag hold stable. No frame is dropped.
- parity_type and two_stop are sampled only at accept; changing them mid-stream affects only later frames.
- Error rules, evaluated on the accepted frame:
  - start_err = in_start.
  - stop_err = !in_stop[0] || (two_stop && !in_stop[1]).
  - parity_err: for odd, parity_err = (in_parity != ~^in_data). For even, parity_err = (in_parity != ^in_data). For none, parity_err = 0.
- break_flag=1 when in_start=0, in_data is all zeros and in_stop[0]=0; in_parity is ignored. A break still reports stop_err=1.
- Counters:
  - On each accept, frame_cnt increments by 1.
  - Each error counter increments by 1 when its error bit is set for that frame.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- clear_cnt sets every counter to 0. If an accept occurs in the same cycle, clear wins and the frame is then counted, so each counter is left at 1 if it would have incremented, else 0.
- Reset mid-handshake discards any held frame. Counters return to 0.

Test Plan:
1. Basic odd-parity frame. DATA_W=8, parity_type=01, two_stop=0. Drive in_data=8'h35 (4 ones), in_parity=1, in_start=0, in_stop=01, out_ready=1. Required: out_data=8'h35, error_flag=000 one cycle after accept, frame_cnt=1.
2. Even-parity error. parity_type=10. Drive in_data=8'h07 (3 ones), in_parity=0. Required: error_flag=001, parity_err_cnt=1. The same frame with parity_type=00 gives error_flag=000.
3. Combined start and two-stop errors. two_stop=1, in_start=1, in_stop=01, in_data=8'h00 with correct parity. Required: error_flag=110 and break_flag=0.
4. Break frame. in_start=0, in_data=8'h00, in_stop=00. Required: break_flag=1, error_flag bit2=1, stop_err_cnt incremented.
5. Backpressure. Hold out_ready=0 after one accept, keep in_valid=1 with a second frame 8'hA5. Required: in_ready=0, and out_data stays at the first frame. Raise out_ready: 8'hA5 appears the next cycle, with no loss and no duplicate. frame_cnt=2.
6. Saturation and clear. CNT_W=4. Send 20 frames with start_err. Required: start_err_cnt=15, frame_cnt=15. Then assert clear_cnt in the same cycle as a start_err accept. Required: start_err_cnt=1 and frame_cnt=1. Assert reset_n=0 mid-stream: out_valid=0 immediately.

Source files
------------

// File: rtl/uart_rx_frame_checker_if.sv
// Handshake and result bundle for the UART Rx frame checker.
// master = frame producer / result consumer side, slave = the checker.
interface uart_rx_frame_checker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  // upstream frame handshake
  logic              in_valid;
  logic              in_ready;
  logic              in_start;
  logic [DATA_W-1:0] in_data;
  logic              in_parity;
  logic [1:0]        in_stop;
  // per-frame configuration, captured at accept
  logic [1:0]        parity_type;
  logic              two_stop;
  // downstream result handshake
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        error_flag;
  logic              break_flag;
  // statistics
  logic              clear_cnt;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  parity_err_cnt;
  logic [CNT_W-1:0]  start_err_cnt;
  logic [CNT_W-1:0]  stop_err_cnt;

  modport slave (
    input  in_valid, in_start, in_data, in_parity, in_stop,
    input  parity_type, two_stop, out_ready, clear_cnt,
    output in_ready, out_valid, out_data, error_flag, break_flag,
    output frame_cnt, parity_err_cnt, start_err_cnt, stop_err_cnt
  );

  modport master (
    output in_valid, in_start, in_data, in_parity, in_stop,
    output parity_type, two_stop, out_ready, clear_cnt,
    input  in_ready, out_valid, out_data, error_flag, break_flag,
    input  frame_cnt, parity_err_cnt, start_err_cnt, stop_err_cnt
  );
endinterface

// File: rtl/uart_rx_frame_checker.sv
// UART Rx frame checker: validates start/parity/stop fields of a
// deserialised frame, flags line breaks, forwards data with a 3-bit
// error flag through a single result register, and keeps saturating
// per-error statistics counters. DATA_W is meant for 5..9.
module uart_rx_frame_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic                     clock,
  input logic                     reset_n,
  uart_rx_frame_checker_if.slave  bus
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  // counter lanes: 0 frames, 1 parity, 2 start, 3 stop
  localparam int NUM_CNT = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]              state_q;
  logic                    accept;
  logic                    data_xor;
  logic                    parity_err;
  logic                    start_err;
  logic                    stop_err;
  logic                    is_break;
  logic [DATA_W-1:0]       data_q;
  logic [2:0]              err_q;
  logic                    brk_q;
  logic [NUM_CNT-1:0]      cnt_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q;

  assign bus.out_valid = (state_q == S_FULL);
  // the register can take a new frame whenever its content leaves this cycle
  assign bus.in_ready  = !bus.out_valid || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;

  // field checks on the frame currently offered
  always_comb begin
    data_xor   = ^bus.in_data;
    parity_err = 1'b0;
    case (bus.parity_type)
      2'b01:   parity_err = (bus.in_parity != ~data_xor);
      2'b10:   parity_err = (bus.in_parity != data_xor);
      default: parity_err = 1'b0;
    endcase
    start_err = bus.in_start;
    stop_err  = !bus.in_stop[0] || (bus.two_stop && !bus.in_stop[1]);
    // a break holds the line low through the first stop bit; parity is don't-care
    is_break  = !bus.in_start && (bus.in_data == '0) && !bus.in_stop[0];
  end

  // result-register occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)             state_q <= S_EMPTY;
    else if (accept)          state_q <= S_FULL;
    else if (bus.out_ready)   state_q <= S_EMPTY;
  end

  // result payload, loaded only on accept so it holds under backpressure
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      err_q  <= '0;
      brk_q  <= 1'b0;
    end else if (accept) begin
      data_q <= bus.in_data;
      err_q  <= {stop_err, start_err, parity_err};
      brk_q  <= is_break;
    end
  end

  assign bus.out_data   = data_q;
  assign bus.error_flag = err_q;
  assign bus.break_flag = brk_q;

  assign cnt_inc = {accept && stop_err, accept && start_err,
                    accept && parity_err, accept};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      // saturating counter; clear takes priority but the same-cycle frame still counts
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
          cnt_q[gi] <= '0;
        else if (bus.clear_cnt)
          cnt_q[gi] <= CNT_W'(cnt_inc[gi]);
        else if (cnt_inc[gi] && (cnt_q[gi] != CNT_MAX))
          cnt_q[gi] <= cnt_q[gi] + 1'b1;
      end
    end
  endgenerate

  assign bus.frame_cnt      = cnt_q[0];
  assign bus.parity_err_cnt = cnt_q[1];
  assign bus.start_err_cnt  = cnt_q[2];
  assign bus.stop_err_cnt   = cnt_q[3];

endmodule
